// File: rtl/muldiv_ctrl.sv
// Multi-cycle sequencer for the EX-stage multiply/divide units: latches one op, drives the
// shared mul/div interfaces, stalls EX, then presents a HI/LO write. Optional: MULDIV_DIV0_BYPASS_EN.
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_type,
  input  logic [31:0] op_src1,
  input  logic [31:0] op_src2,
  input  logic        flush,
  input  logic        ex_advance,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        stallreq,
  output logic        busy,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);

  state_t      state, state_nx;
  logic [1:0]  type_q;
  logic [31:0] src1_q, src2_q;
  logic [3:0]  cnt;
  logic [63:0] res_q;
  logic        accept, capture;
  logic [63:0] capture_val;

  // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    capture     = 1'b0;
    capture_val = 64'd0;
    stallreq    = 1'b0;
    mul_signed  = 1'b0;
    mul_ina     = 32'd0;
    mul_inb     = 32'd0;
    div_start   = 1'b0;
    div_signed  = 1'b0;
    div_opdata1 = 32'd0;
    div_opdata2 = 32'd0;
    div_annul   = 1'b0;
    hi_we       = 1'b0;
    lo_we       = 1'b0;
    hi_wdata    = 32'd0;
    lo_wdata    = 32'd0;

    unique case (state)
      S_IDLE: begin
        stallreq = op_valid & ~flush;
        if (op_valid && !flush) begin
          accept = 1'b1;
          if (!op_type[1]) begin
            state_nx = S_MUL;
          end else begin
`ifdef MULDIV_DIV0_BYPASS_EN
            // Divide-by-zero never reaches the divider; result is architecturally fixed.
            if (op_src2 == 32'd0) begin
              state_nx    = S_DONE;
              capture     = 1'b1;
              capture_val = {op_src1, 32'hFFFF_FFFF};
            end else begin
              state_nx = S_DIV;
            end
`else
            state_nx = S_DIV;
`endif
          end
        end
      end

      S_MUL: begin
        stallreq   = 1'b1;
        mul_signed = (type_q == 2'b00);
        mul_ina    = src1_q;
        mul_inb    = src2_q;
        if (flush) begin
          state_nx = S_IDLE;
        end else if (cnt == 4'd1) begin
          capture     = 1'b1;
          capture_val = mul_result;
          state_nx    = S_DONE;
        end
      end

      S_DIV: begin
        stallreq    = 1'b1;
        div_signed  = (type_q == 2'b10);
        div_opdata1 = src1_q;
        div_opdata2 = src2_q;
        if (flush) begin
          div_annul = 1'b1;
          state_nx  = S_IDLE;
        end else if (div_ready) begin
          capture     = 1'b1;
          capture_val = div_result;
          state_nx    = S_DONE;
        end else begin
          div_start = 1'b1;
        end
      end

      S_DONE: begin
        hi_we    = 1'b1;
        lo_we    = 1'b1;
        hi_wdata = res_q[63:32];
        lo_wdata = res_q[31:0];
        if (flush || ex_advance) state_nx = S_IDLE;
      end

      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: these are plain registers (no memory arrays), so every one is reset to a known zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      type_q <= 2'b00;
      src1_q <= 32'd0;
      src2_q <= 32'd0;
      cnt    <= 4'd0;
      res_q  <= 64'd0;
    end else begin
      if (accept) begin
        type_q <= op_type;
        src1_q <= op_src1;
        src2_q <= op_src2;
      end
      if (accept && !op_type[1]) cnt <= MUL_LAT_C;
      else if (state == S_MUL)   cnt <= cnt - 4'd1;
      if (capture) res_q <= capture_val;
    end
  end

endmodule
